rv_wb_stage: RTL and testbench
==============================

// Module: rv_wb_stage
// PURPOSE
//  Write-back result select for the single-cycle RV32I core. Chooses the value
//  written to the register file from: load data, ALU result, U-type/jump
//  address sources. The selection is driven by the memtoreg control and the
//  instruction opcode. The result is registered (one cycle) before the
//  regfile write port; it sits after the data-memory/ALU stage.
// PARAMETERS
//  WIDTH  32  datapath width of all data inputs and of wb_data
// PORTS
//  clk               in   1      system clock, all state on rising edge
//  rst               in   1      synchronous, active-high reset
//  mem_out           in   WIDTH  load data from data memory
//  alu_out           in   WIDTH  ALU result
//  return_addr       in   WIDTH  PC+imm target (AUIPC result)
//  imm_out           in   WIDTH  U-type immediate, already shifted (LUI result)
//  pc_signed_offset  in   WIDTH  link value PC+4 (JAL/JALR result)
//  memtoreg          in   2      write-back source select
//  opcode_out_d      in   7      opcode of the instruction being written back
//  wb_data           out  WIDTH  registered write-back data
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst is synchronous and active-high.
//  - Combinational select sel_d:
//      memtoreg=00 -> mem_out
//      memtoreg=01 -> alu_out
//      memtoreg=10 -> decode opcode_out_d:
//          7'b0010111 (AUIPC) -> return_addr
//          7'b0110111 (LUI)   -> imm_out
//          7'b1101111 (JAL)   -> pc_signed_offset
//          7'b1100111 (JALR)  -> pc_signed_offset
//          any other opcode   -> alu_out
//      memtoreg=11 -> alu_out (reserved; no X propagation)
//  - Register: on every rising clk, wb_data <= rst ? 0 : sel_d.
//  - Latency: exactly 1 cycle from input change to wb_data; no enable, no stall.
//  - Reset: wb_data = 0 on the first edge with rst=1, held while rst=1.
//    Reset mid-stream drops the in-flight value; the first edge after rst
//    falls loads the current sel_d.
//  - Opcode is ignored unless memtoreg=10. Data is passed bit-exact; no
//    extension, truncation or arithmetic.
//  - X/Z on an unselected input must not affect wb_data. No latches; all
//    case statements carry a default.
// TESTING
//  - Reset: rst=1 for 2 cycles with all inputs nonzero -> wb_data=0; release
//    -> next edge loads the selected value.
//  - Inputs mem=AAAAAAAA, alu=BBBBBBBB, ret=11111111, imm=22222222,
//    pcoff=33333333:
//      memtoreg=00 -> AAAAAAAA
//      memtoreg=01 -> BBBBBBBB
//    Each result appears one cycle after the inputs are applied.
//  - Same inputs, memtoreg=10:
//      opcode 0010111 -> 11111111
//      opcode 0110111 -> 22222222
//      opcode 1101111 -> 33333333
//      opcode 1100111 -> 33333333
//      opcode 0110011 -> BBBBBBBB
//  - All inputs 0, memtoreg=00 -> 00000000.
//    memtoreg=11 with alu=EEEEEEEE -> EEEEEEEE.
//  - Inputs mem=FFFFFFFF, alu=EEEEEEEE, ret=DDDDDDDD, imm=CCCCCCCC,
//    pcoff=BBBBBBBB:
//      memtoreg 00 / 01 -> FFFFFFFF / EEEEEEEE
//      memtoreg 10 with AUIPC / LUI / JAL -> DDDDDDDD / CCCCCCCC / BBBBBBBB
//  - Assert rst for one cycle between back-to-back selects -> 0 for exactly
//    that cycle, then the selected value resumes.

Source files
------------

// File: rtl/rv_wb_stage_if.sv
// Write-back stage bus: result sources and select controls in, registered
// write-back data out.
interface rv_wb_stage_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] mem_out;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] return_addr;
    logic [WIDTH-1:0] imm_out;
    logic [WIDTH-1:0] pc_signed_offset;
    logic [1:0]       memtoreg;
    logic [6:0]       opcode_out_d;
    logic [WIDTH-1:0] wb_data;

    // Upstream datapath side: drives the sources and controls.
    modport master (
        output mem_out,
        output alu_out,
        output return_addr,
        output imm_out,
        output pc_signed_offset,
        output memtoreg,
        output opcode_out_d,
        input  wb_data
    );

    // Write-back stage side.
    modport slave (
        input  mem_out,
        input  alu_out,
        input  return_addr,
        input  imm_out,
        input  pc_signed_offset,
        input  memtoreg,
        input  opcode_out_d,
        output wb_data
    );
endinterface

// File: rtl/rv_wb_stage.sv
// RV32I write-back result select: picks load data, ALU result or a
// U-type/jump source and registers it for the register-file write port.
module rv_wb_stage #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    rv_wb_stage_if.slave  bus
);
    typedef enum logic [1:0] {
        WB_MEM  = 2'b00,
        WB_ALU  = 2'b01,
        WB_OPC  = 2'b10,
        WB_RSVD = 2'b11
    } wb_src_t;

    typedef enum logic [6:0] {
        OP_AUIPC = 7'b0010111,
        OP_LUI   = 7'b0110111,
        OP_JAL   = 7'b1101111,
        OP_JALR  = 7'b1100111
    } wb_opcode_t;

    logic [WIDTH-1:0] opc_d;
    logic [WIDTH-1:0] sel_d;
    logic [WIDTH-1:0] wb_q;

    // Opcode decode only matters when memtoreg selects it; unknown opcodes
    // fall back to the ALU result.
    always_comb begin
        opc_d = bus.alu_out;
        case (bus.opcode_out_d)
            OP_AUIPC: opc_d = bus.return_addr;
            OP_LUI:   opc_d = bus.imm_out;
            OP_JAL:   opc_d = bus.pc_signed_offset;
            OP_JALR:  opc_d = bus.pc_signed_offset;
            default:  opc_d = bus.alu_out;
        endcase
    end

    always_comb begin
        sel_d = bus.alu_out;
        case (bus.memtoreg)
            WB_MEM:  sel_d = bus.mem_out;
            WB_ALU:  sel_d = bus.alu_out;
            WB_OPC:  sel_d = opc_d;
            WB_RSVD: sel_d = bus.alu_out;
            default: sel_d = bus.alu_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= sel_d;
        end
    end

    assign bus.wb_data = wb_q;
endmodule

// File: tb/tb_rv_wb_stage.sv
// Directed bench for rv_wb_stage: hand-computed expected values checked one
// cycle after each input change.
module tb_rv_wb_stage;
    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    rv_wb_stage_if #(.WIDTH(32)) bus ();

    rv_wb_stage #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] exp);
        total++;
        assert (bus.wb_data === exp) passed++;
        else $error("FAIL %s: wb_data=%h expected=%h", tag, bus.wb_data, exp);
    endtask

    task automatic load(input logic [31:0] m, input logic [31:0] a, input logic [31:0] r,
                        input logic [31:0] i, input logic [31:0] p);
        bus.mem_out          = m;
        bus.alu_out          = a;
        bus.return_addr      = r;
        bus.imm_out          = i;
        bus.pc_signed_offset = p;
    endtask

    task automatic sel(input logic [1:0] m2r, input logic [6:0] op);
        bus.memtoreg     = m2r;
        bus.opcode_out_d = op;
    endtask

    initial begin
        rst = 1'b1;
        load(32'hAAAAAAAA, 32'hBBBBBBBB, 32'h11111111, 32'h22222222, 32'h33333333);
        sel(2'b01, 7'b0110111);

        // Reset held two cycles with nonzero inputs.
        tick(); chk("rst_cyc1", 32'h0);
        tick(); chk("rst_cyc2", 32'h0);
        rst = 1'b0;
        tick(); chk("rst_release", 32'hBBBBBBBB);

        sel(2'b00, 7'b0000000);
        #1 chk("latency_hold", 32'hBBBBBBBB);
        tick(); chk("m2r_00", 32'hAAAAAAAA);
        sel(2'b01, 7'b0010111);
        tick(); chk("m2r_01_op_ignored", 32'hBBBBBBBB);

        sel(2'b10, 7'b0010111); tick(); chk("auipc", 32'h11111111);
        sel(2'b10, 7'b0110111); tick(); chk("lui",   32'h22222222);
        sel(2'b10, 7'b1101111); tick(); chk("jal",   32'h33333333);
        sel(2'b10, 7'b1100111); tick(); chk("jalr",  32'h33333333);
        sel(2'b10, 7'b0110011); tick(); chk("rtype", 32'hBBBBBBBB);
        sel(2'b10, 7'b0000011); tick(); chk("load_op_fallback", 32'hBBBBBBBB);

        load(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        sel(2'b00, 7'b0000000); tick(); chk("all_zero", 32'h0);
        load(32'h0, 32'hEEEEEEEE, 32'h0, 32'h0, 32'h0);
        sel(2'b11, 7'b0010111); tick(); chk("m2r_11", 32'hEEEEEEEE);

        load(32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB);
        sel(2'b00, 7'b0000000); tick(); chk("set2_mem",   32'hFFFFFFFF);
        sel(2'b01, 7'b0000000); tick(); chk("set2_alu",   32'hEEEEEEEE);
        sel(2'b10, 7'b0010111); tick(); chk("set2_auipc", 32'hDDDDDDDD);
        sel(2'b10, 7'b0110111); tick(); chk("set2_lui",   32'hCCCCCCCC);
        sel(2'b10, 7'b1101111); tick(); chk("set2_jal",   32'hBBBBBBBB);

        // Mid-stream reset: exactly one zero cycle, then selection resumes.
        sel(2'b00, 7'b0000000); tick(); chk("pre_rst", 32'hFFFFFFFF);
        rst = 1'b1;
        sel(2'b01, 7'b0000000); tick(); chk("mid_rst", 32'h0);
        rst = 1'b0;
        tick(); chk("post_rst", 32'hEEEEEEEE);

        // Unknowns on unselected sources must not leak through.
        load('x, 32'h12345678, 'x, 'x, 'x);
        sel(2'b01, 7'b0010111); tick(); chk("x_unselected_alu", 32'h12345678);
        load('x, 'x, 'x, 32'h9ABCDEF0, 'x);
        sel(2'b10, 7'b0110111); tick(); chk("x_unselected_lui", 32'h9ABCDEF0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
